// File: rtl/out_fifo_port.sv
// Memory-mapped E100 output port with a DEPTH-entry FIFO drained by the device
// through a valid/ack handshake, plus status (read) and control (write) words.
module out_fifo_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clock_valid,
  input  logic [31:0]      port_number,
  input  logic [31:0]      address,
  input  logic             memory_drive,
  input  logic             memory_write,
  input  logic [31:0]      bus,
  output logic [31:0]      bus_out,
  output logic             bus_drive,
  output logic [WIDTH-1:0] dev_data,
  output logic             dev_valid,
  input  logic             dev_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic [WIDTH-1:0] last_written;

  logic data_hit;
  logic stat_hit;
  logic ctrl_hit;
  logic full;
  logic data_write;
  logic push;
  logic pop;
  logic flush;
  logic clr_ovf;
  logic ovf_set;

  // Sibling addresses wrap modulo 2^32 through plain 32-bit addition.
  assign data_hit = (address == port_number);
  assign stat_hit = (address == port_number + 32'd1);
  assign ctrl_hit = (address == port_number + 32'd2);

  assign full       = (count == CW'(DEPTH));
  assign dev_valid  = (count != '0);
  assign data_write = memory_write & data_hit;
  assign pop        = dev_valid & dev_ack;
  // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
  assign push       = data_write & (~full | pop);
  assign ovf_set    = data_write & full & ~pop;
  assign flush      = memory_write & ctrl_hit & bus[0];
  assign clr_ovf    = memory_write & ctrl_hit & bus[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      overflow     <= 1'b0;
      last_written <= '0;
    end else if (clock_valid) begin
      if (data_write) begin
        last_written <= bus[WIDTH-1:0];
      end
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
      if (clr_ovf) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clock) begin
    if (clock_valid && push) begin
      mem[wr_ptr] <= bus[WIDTH-1:0];
    end
  end

  assign dev_data  = dev_valid ? mem[rd_ptr] : '0;
  assign bus_drive = memory_drive & (data_hit | stat_hit);

  always_comb begin
    bus_out = '0;
    if (memory_drive && data_hit) begin
      bus_out[WIDTH-1:0] = last_written;
    end else if (memory_drive && stat_hit) begin
      bus_out[0]    = ~dev_valid;
      bus_out[1]    = full;
      bus_out[2]    = overflow;
      bus_out[15:8] = 8'(count);
    end
  end

endmodule

// File: tb/tb_out_fifo_port.sv
// Directed bench for out_fifo_port: a 32-bit/8-deep port plus an 8-bit port
// for the truncation case; expected values are hand-computed constants.
module tb_out_fifo_port;

  logic        clock;
  logic        reset;
  logic        clock_valid;
  logic [31:0] port_number;
  logic [31:0] address;
  logic        memory_drive;
  logic        memory_write;
  logic        memory_write8;
  logic [31:0] bus;
  logic        dev_ack;

  logic [31:0] bus_out;
  logic        bus_drive;
  logic [31:0] dev_data;
  logic        dev_valid;

  logic [31:0] bus_out8;
  logic        bus_drive8;
  logic [7:0]  dev_data8;
  logic        dev_valid8;

  int vectors;
  int miscompares;

  out_fifo_port #(.WIDTH(32), .DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .clock_valid  (clock_valid),
    .port_number  (port_number),
    .address      (address),
    .memory_drive (memory_drive),
    .memory_write (memory_write),
    .bus          (bus),
    .bus_out      (bus_out),
    .bus_drive    (bus_drive),
    .dev_data     (dev_data),
    .dev_valid    (dev_valid),
    .dev_ack      (dev_ack)
  );

  out_fifo_port #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clock        (clock),
    .reset        (reset),
    .clock_valid  (clock_valid),
    .port_number  (port_number),
    .address      (address),
    .memory_drive (memory_drive),
    .memory_write (memory_write8),
    .bus          (bus),
    .bus_out      (bus_out8),
    .bus_drive    (bus_drive8),
    .dev_data     (dev_data8),
    .dev_valid    (dev_valid8),
    .dev_ack      (dev_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One enabled edge with an optional write; outputs are stable 1ns later.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    memory_write = we;
    address      = addr;
    bus          = data;
    @(posedge clock);
    #1;
    memory_write = 1'b0;
  endtask

  task automatic read_bus(input logic [31:0] addr, output logic [31:0] val, output logic drv);
    memory_drive = 1'b1;
    address      = addr;
    #1;
    val          = bus_out;
    drv          = bus_drive;
    memory_drive = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] val;
    logic        drv;
    read_bus(32'h81, val, drv);
    checkOutput({tag, "_drv"}, {31'd0, drv}, 32'd1);
    checkOutput(tag, val, exp);
  endtask

  initial begin
    logic [31:0] val;
    logic        drv;
    logic [31:0] drain_exp [8];

    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    clock_valid   = 1'b1;
    port_number   = 32'h80;
    address       = 32'h0;
    memory_drive  = 1'b0;
    memory_write  = 1'b0;
    memory_write8 = 1'b0;
    bus           = 32'h0;
    dev_ack       = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    checkOutput("rst_valid", {31'd0, dev_valid}, 32'd0);
    checkOutput("rst_data", dev_data, 32'd0);
    checkOutput("rst_bus_out", bus_out, 32'd0);
    checkOutput("rst_bus_drive", {31'd0, bus_drive}, 32'd0);
    check_status("rst_status", 32'h0000_0001);

    // WIDTH=8 instance: upper bits of the store are discarded.
    memory_write8 = 1'b1;
    applyStimulus(1'b0, 32'h80, 32'hDEAD_BEEF);
    memory_write8 = 1'b0;
    checkOutput("w8_dev_data", {24'd0, dev_data8}, 32'h0000_00EF);
    memory_drive = 1'b1;
    address      = 32'h80;
    #1;
    checkOutput("w8_read", bus_out8, 32'h0000_00EF);
    checkOutput("w8_drive", {31'd0, bus_drive8}, 32'd1);
    memory_drive = 1'b0;

    // No same-cycle bypass: valid only after the write edge.
    memory_write = 1'b1;
    address      = 32'h80;
    bus          = 32'h11;
    #1;
    checkOutput("no_bypass", {31'd0, dev_valid}, 32'd0);
    applyStimulus(1'b1, 32'h80, 32'h11);
    checkOutput("fill_valid", {31'd0, dev_valid}, 32'd1);
    checkOutput("fill_head", dev_data, 32'h11);
    applyStimulus(1'b1, 32'h80, 32'h22);
    applyStimulus(1'b1, 32'h80, 32'h33);
    check_status("fill_status", 32'h0000_0300);
    read_bus(32'h80, val, drv);
    checkOutput("fill_lastw", val, 32'h33);

    // Status write is ignored; control reads do not drive the bus.
    applyStimulus(1'b1, 32'h81, 32'hFFFF_FFFF);
    check_status("stat_write_ign", 32'h0000_0300);
    read_bus(32'h82, val, drv);
    checkOutput("ctrl_rd_drive", {31'd0, drv}, 32'd0);
    checkOutput("ctrl_rd_data", val, 32'd0);

    dev_ack = 1'b1;
    checkOutput("drain0", dev_data, 32'h11);
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("drain1", dev_data, 32'h22);
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("drain2", dev_data, 32'h33);
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("drain_empty", {31'd0, dev_valid}, 32'd0);
    checkOutput("drain_empty_d", dev_data, 32'd0);
    // Ack while empty must not underflow.
    applyStimulus(1'b0, 32'h0, 32'h0);
    dev_ack = 1'b0;
    check_status("drain_status", 32'h0000_0001);

    // Overflow: nine stores into eight slots.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 32'h80, 32'hA0 + i);
    end
    check_status("ovf_status", 32'h0000_0806);
    read_bus(32'h80, val, drv);
    checkOutput("ovf_lastw", val, 32'hA8);
    applyStimulus(1'b1, 32'h82, 32'h2);
    check_status("ovf_clear", 32'h0000_0802);

    // Full with simultaneous push and pop: push accepted, no overflow.
    dev_ack = 1'b1;
    applyStimulus(1'b1, 32'h80, 32'hB0);
    dev_ack = 1'b0;
    check_status("full_pp_status", 32'h0000_0802);
    drain_exp = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hB0};
    dev_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("full_drain%0d", i), dev_data, drain_exp[i]);
      applyStimulus(1'b0, 32'h0, 32'h0);
    end
    dev_ack = 1'b0;
    checkOutput("full_drain_end", {31'd0, dev_valid}, 32'd0);

    // clock_valid=0 freezes both push and pop.
    applyStimulus(1'b1, 32'h80, 32'hC1);
    applyStimulus(1'b1, 32'h80, 32'hC2);
    clock_valid = 1'b0;
    dev_ack     = 1'b1;
    applyStimulus(1'b1, 32'h80, 32'hC3);
    dev_ack     = 1'b0;
    clock_valid = 1'b1;
    check_status("cv0_status", 32'h0000_0200);
    checkOutput("cv0_head", dev_data, 32'hC1);
    read_bus(32'h80, val, drv);
    checkOutput("cv0_lastw", val, 32'hC2);

    // Flush with five entries, with a competing ack.
    applyStimulus(1'b1, 32'h80, 32'hC4);
    applyStimulus(1'b1, 32'h80, 32'hC5);
    applyStimulus(1'b1, 32'h80, 32'hC6);
    check_status("pre_flush", 32'h0000_0500);
    dev_ack = 1'b1;
    applyStimulus(1'b1, 32'h82, 32'h1);
    dev_ack = 1'b0;
    checkOutput("flush_valid", {31'd0, dev_valid}, 32'd0);
    check_status("flush_status", 32'h0000_0001);

    // Push and pop together at count=1.
    applyStimulus(1'b1, 32'h80, 32'hD1);
    dev_ack = 1'b1;
    applyStimulus(1'b1, 32'h80, 32'hD2);
    dev_ack = 1'b0;
    check_status("c1_pp_status", 32'h0000_0100);
    checkOutput("c1_pp_head", dev_data, 32'hD2);

    // Reset mid-operation with four entries.
    applyStimulus(1'b1, 32'h80, 32'hE1);
    applyStimulus(1'b1, 32'h80, 32'hE2);
    applyStimulus(1'b1, 32'h80, 32'hE3);
    check_status("pre_reset", 32'h0000_0400);
    reset       = 1'b1;
    clock_valid = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    reset       = 1'b0;
    clock_valid = 1'b1;
    checkOutput("mid_rst_valid", {31'd0, dev_valid}, 32'd0);
    check_status("mid_rst_status", 32'h0000_0001);
    read_bus(32'h80, val, drv);
    checkOutput("mid_rst_lastw", val, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/out_fifo_port.md
Name: out_fifo_port

Overview:
- Next-generation memory-mapped E100 output port, width-parametrised, with a DEPTH-entry FIFO between the E100 and the I/O device.
- E100 stores are queued rather than overwriting a single register; the device drains them with a valid/ack handshake.
- Adds a readable status word (count/full/empty/overflow) and a control word (flush, clear overflow).
- Single clock domain; the device side runs on the E100 clock.

Parameters:
- WIDTH, 32, data bits per entry (1..32); bus bits above WIDTH are ignored on write and read back as 0.
- DEPTH, 8, FIFO entries; power of two, 2..128.

Ports:
- clock  input  1  E100 clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- clock_valid  input  1  clock enable; when 0 no state changes.
- port_number  input  32  base address: data = port_number, status = port_number+1, control = port_number+2.
- address  input  32  E100 memory address.
- memory_drive  input  1  E100 read strobe.
- memory_write  input  1  E100 write strobe.
- bus  input  32  E100 write data.
- bus_out  output  32  read data for the data/status addresses.
- bus_drive  output  1  high when this block supplies bus_out.
- dev_data  output  WIDTH  FIFO head entry.
- dev_valid  output  1  FIFO non-empty.
- dev_ack  input  1  device consumes head this cycle.

Behaviour:
- Clock and reset:
  - All state updates on the rising edge of clock, and only when clock_valid=1.
  - reset=1 at an edge (regardless of clock_valid) sets count=0, rd/wr pointers=0, overflow=0, last_written=0.
  - FIFO storage is not reset.
- Push:
  - Condition: memory_write & address==port_number.
  - Stores bus[WIDTH-1:0] at wr_ptr; wr_ptr advances mod DEPTH; count+1.
  - last_written <= bus[WIDTH-1:0] on every data-address write, even if dropped.
- Pop:
  - Condition: dev_valid & dev_ack; rd_ptr advances mod DEPTH; count-1.
  - dev_ack while dev_valid=0 is ignored.
- Full, empty and simultaneous events:
  - Push while full with no pop in the same cycle: data dropped, count unchanged, overflow set (sticky).
  - Push and pop in the same cycle: both occur and count is unchanged, including when full (push is accepted) and when count=1.
  - Push to an empty FIFO: dev_valid rises the cycle after the write edge (1-cycle latency); there is no same-cycle bypass.
- Device outputs:
  - dev_valid = (count != 0), from registered state.
  - dev_data = mem[rd_ptr] when dev_valid, else 0.
  - Holding dev_ack=1 drains one entry per enabled cycle.
- Control (write to port_number+2):
  - bit0 = flush: count, rd_ptr and wr_ptr go to 0.
  - bit1 = clear overflow.
  - Other bits are ignored.
  - Flush takes priority over a same-cycle pop.
  - Overflow clear takes priority over a same-cycle set.
  - A write to the status address is ignored.
- Reads (combinational):
  - bus_drive = memory_drive & (address==port_number | address==port_number+1).
  - Data address returns {0, last_written}.
  - Status address returns: [0]=empty, [1]=full, [2]=overflow, [15:8]=count (zero-extended), all other bits 0.
  - Control address reads give bus_drive=0.
  - bus_out=0 whenever bus_drive=0.
- Address arithmetic: port_number+1 and port_number+2 are 32-bit and wrap modulo 2^32.
- Reset mid-operation: pending entries are discarded; dev_valid=0 on the cycle after the reset edge.
- Reset values of outputs: bus_out=0, bus_drive=0 (absent memory_drive), dev_valid=0, dev_data=0.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 to port_number=0x80 with dev_ack=0:
  - dev_valid=1 one cycle after the first write; dev_data=0x11.
  - Status read at 0x81 returns 0x0000_0300.
- Hold dev_ack=1 after that fill:
  - dev_data reads 0x11, 0x22, 0x33 on consecutive cycles, then dev_valid=0.
  - Status reads 0x0000_0001.
- DEPTH=8, write 9 values with no ack:
  - Status reads 0x0000_0806; the 9th value is absent from the drain sequence.
  - Data-address read returns the 9th value.
  - Writing 0x2 to 0x82 clears the status overflow bit.
- FIFO full with a simultaneous write and dev_ack:
  - Count stays 8; the new value appears 8th in the drain sequence; overflow stays 0.
- WIDTH=8, write 0xDEADBEEF:
  - dev_data=0xEF; data read returns 0x0000_00EF.
- clock_valid=0 during a write and an ack → count unchanged.
- Flush (write 0x1 to 0x82) with 5 entries → dev_valid=0 next cycle.
- Reset asserted with 4 entries → status returns 0x1 after reset.
